// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one ALU between two valid/ready
// requesters, with registered operands, registered result and a debug
// completion counter.

// Combinational N-bit ALU: add / or / sub / xor, carry and borrow dropped.
module alu #(
   parameter int unsigned N = 4
) (
   input  logic [1:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] y
);

   // Opcode decode; results wrap modulo 2^N.
   always_comb begin
      y = '0;
      unique case (op)
         2'b00: y = a + b;
         2'b01: y = a | b;
         2'b10: y = a - b;
         2'b11: y = a ^ b;
         default: y = '0;
      endcase
   end

endmodule

module alu_share_ctrl #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic [1:0]   req0_op,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   input  logic [1:0]   req1_op,
   output logic         req1_ready,
   output logic         rsp_valid,
   output logic         rsp_id,
   output logic [N-1:0] rsp_result,
   input  logic         rsp_ready,
   output logic [7:0]   op_count
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         state;
   state_t         next_state;
   logic           prio;
   logic           grant0;
   logic           grant1;
   logic           accept;
   logic           capture;
   logic           retire;
   logic [N-1:0]   lat_a;
   logic [N-1:0]   lat_b;
   logic [1:0]     lat_op;
   logic           lat_id;
   logic [N-1:0]   alu_y;
   logic [CNT_W-1:0] cnt;

   assign op_count = cnt;

   // Single shared ALU, always fed from the latched operands.
   alu #(.N(N)) u_alu (
      .op (lat_op),
      .a  (lat_a),
      .b  (lat_b),
      .y  (alu_y)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Arbitration, next state and combinational readys; prio only breaks ties.
   always_comb begin
      next_state = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      accept     = 1'b0;
      capture    = 1'b0;
      retire     = 1'b0;
      grant1     = req1_valid && (!req0_valid || prio);
      grant0     = req0_valid && !grant1;
      unique case (state)
         IDLE: begin
            req0_ready = grant0;
            req1_ready = grant1;
            if (grant0 || grant1) begin
               accept     = 1'b1;
               next_state = EXEC;
            end
         end
         EXEC: begin
            capture    = 1'b1;
            next_state = RESP;
         end
         RESP: begin
            if (rsp_valid && rsp_ready) begin
               retire     = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Operand latch, result capture, response retire and completion count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio       <= 1'b0;
         lat_a      <= '0;
         lat_b      <= '0;
         lat_op     <= '0;
         lat_id     <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         cnt        <= '0;
      end else begin
         if (accept) begin
            lat_a  <= grant1 ? req1_a  : req0_a;
            lat_b  <= grant1 ? req1_b  : req0_b;
            lat_op <= grant1 ? req1_op : req0_op;
            lat_id <= grant1;
            prio   <= ~grant1;
         end
         if (capture) begin
            rsp_result <= alu_y;
            rsp_id     <= lat_id;
            rsp_valid  <= 1'b1;
         end
         if (retire) begin
            rsp_valid <= 1'b0;
            cnt       <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed and random-soak bench for alu_share_ctrl (N = 4).
module tb_alu_share_ctrl;

   localparam int unsigned N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req1_valid;
   logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [1:0]   req0_op, req1_op;
   logic         req0_ready, req1_ready;
   logic         rsp_valid, rsp_id, rsp_ready;
   logic [N-1:0] rsp_result;
   logic [7:0]   op_count;

   int total = 0;
   int bad   = 0;
   int exp_count = 0;

   alu_share_ctrl #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .req1_ready (req1_ready),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_ready  (rsp_ready),
      .op_count   (op_count)
   );

   always #5 clk = ~clk;

   // Reference ALU for the random soak.
   function automatic logic [N-1:0] ref_alu(input logic [1:0] op, input logic [N-1:0] a,
                                            input logic [N-1:0] b);
      case (op)
         2'b00:   ref_alu = a + b;
         2'b01:   ref_alu = a | b;
         2'b10:   ref_alu = a - b;
         default: ref_alu = a ^ b;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit id, input bit v, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [1:0] op);
      if (id == 1'b0) begin
         req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
      end else begin
         req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
      end
   endtask

   task automatic do_reset;
      rst = 1'b1;
      #1;
      chk("rst_vld", rsp_valid, 0);
      chk("rst_id",  rsp_id, 0);
      chk("rst_res", rsp_result, 0);
      chk("rst_cnt", op_count, 0);
      exp_count = 0;
      tick;
      rst = 1'b0;
   endtask

   // One transaction from a lone requester; optional response stall.
   task automatic send_one(input bit id, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [1:0] op, input logic [N-1:0] exp, input int stall);
      drive(id, 1'b1, a, b, op);
      #1;
      chk("acc_rdy", id ? req1_ready : req0_ready, 1);
      chk("acc_oth", id ? req0_ready : req1_ready, 0);
      tick;
      drive(id, 1'b0, '0, '0, '0);
      chk("exec_vld", rsp_valid, 0);
      chk("exec_rdy", {req0_ready, req1_ready}, 0);
      tick;
      chk("rsp_vld", rsp_valid, 1);
      chk("rsp_id",  rsp_id, id);
      chk("rsp_res", rsp_result, exp);
      if (stall > 0) begin
         rsp_ready = 1'b0;
         drive(!id, 1'b1, 4'h7, 4'h7, 2'b00);
         for (int s = 0; s < stall; s++) begin
            tick;
            chk("bp_vld", rsp_valid, 1);
            chk("bp_id",  rsp_id, id);
            chk("bp_res", rsp_result, exp);
            chk("bp_rdy", {req0_ready, req1_ready}, 0);
            chk("bp_cnt", op_count, exp_count);
         end
         drive(!id, 1'b0, '0, '0, '0);
         rsp_ready = 1'b1;
      end
      tick;
      exp_count = (exp_count + 1) % 256;
      chk("done_vld", rsp_valid, 0);
      chk("done_cnt", op_count, exp_count);
   endtask

   logic [N-1:0] c_exp [4];
   logic [N-1:0] ra, rb;
   logic [1:0]   rop;
   bit           rid;

   initial begin
      rsp_ready = 1'b1;
      drive(1'b0, 1'b0, '0, '0, '0);
      drive(1'b1, 1'b0, '0, '0, '0);

      // Reset values, then the first operation right after release.
      do_reset;
      send_one(1'b0, 4'h3, 4'h5, 2'b00, 4'h8, 0);

      // All opcodes, including carry and borrow wrap.
      send_one(1'b0, 4'hF, 4'h2, 2'b00, 4'h1, 0);
      send_one(1'b1, 4'hF, 4'h2, 2'b10, 4'hD, 0);
      send_one(1'b0, 4'hF, 4'h2, 2'b01, 4'hF, 0);
      send_one(1'b1, 4'hF, 4'h2, 2'b11, 4'hD, 0);
      send_one(1'b0, 4'h2, 4'h5, 2'b10, 4'hD, 0);

      // Back-pressure: five stalled cycles with the other requester waiting.
      send_one(1'b1, 4'h6, 4'h9, 2'b00, 4'hF, 5);

      // Reset during RESP with requester 0 in flight (leaves prio at 1).
      do_reset;
      drive(1'b0, 1'b1, 4'hA, 4'h3, 2'b10);
      #1;
      chk("rr_acc", req0_ready, 1);
      tick;
      drive(1'b0, 1'b0, '0, '0, '0);
      tick;
      chk("rr_vld_pre", rsp_valid, 1);
      rst = 1'b1;
      #1;
      chk("rr_vld", rsp_valid, 0);
      chk("rr_cnt", op_count, 0);
      tick;
      chk("rr_vld_hold", rsp_valid, 0);
      rst = 1'b0;
      drive(1'b0, 1'b1, 4'h1, 4'h1, 2'b00);
      drive(1'b1, 1'b1, 4'h2, 4'h2, 2'b00);
      #1;
      chk("rr_prio0", req0_ready, 1);
      chk("rr_prio1", req1_ready, 0);
      drive(1'b0, 1'b0, '0, '0, '0);
      send_one(1'b1, 4'h4, 4'h3, 2'b11, 4'h7, 0);

      // Contention: both valid, grants must alternate starting from 0.
      do_reset;
      c_exp[0] = 4'h3; c_exp[1] = 4'h5; c_exp[2] = 4'h5; c_exp[3] = 4'h9;
      drive(1'b0, 1'b1, 4'h1, 4'h2, 2'b00);
      drive(1'b1, 1'b1, 4'h6, 4'h3, 2'b11);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("ct_rdy0", req0_ready, (i % 2) == 0);
         chk("ct_rdy1", req1_ready, (i % 2) == 1);
         tick;
         chk("ct_exec_rdy", {req0_ready, req1_ready}, 0);
         if (i == 0)      drive(1'b0, 1'b1, 4'h9, 4'h4, 2'b10);
         else if (i == 1) drive(1'b1, 1'b1, 4'h8, 4'h1, 2'b01);
         else             drive(i[0], 1'b0, '0, '0, '0);
         tick;
         chk("ct_vld", rsp_valid, 1);
         chk("ct_id",  rsp_id, i % 2);
         chk("ct_res", rsp_result, c_exp[i]);
         tick;
         exp_count++;
         chk("ct_cnt", op_count, exp_count);
      end

      // Random soak: 256 operations wrap the counter back to zero.
      do_reset;
      for (int t = 0; t < 256; t++) begin
         rid = 1'($urandom);
         ra  = 4'($urandom);
         rb  = 4'($urandom);
         rop = 2'($urandom);
         send_one(rid, ra, rb, rop, ref_alu(rop, ra, rb), 0);
      end
      chk("wrap_cnt", op_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Controller that shares one `alu` datapath instance (N-bit; ops add/or/sub/xor) between two requesters. It uses a valid/ready handshake and round-robin arbitration, and it registers operands and the result. The block sits between two client blocks and the ALU and returns each result with the ID of the requester that issued it. It also counts completed operations for debug.

## Interface

Parameters:
- `N`, default 4: operand and result width; passed to the internal `alu` instance.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operation pending.
- `req0_a`, `req0_b`  in  N  requester 0 operands.
- `req0_op`  in  2  requester 0 opcode.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req1_valid`, `req1_a`, `req1_b`, `req1_op`, `req1_ready`: same as requester 0, for requester 1.
- `rsp_valid`  out  1  result available.
- `rsp_id`  out  1  requester that issued the result (0 or 1).
- `rsp_result`  out  N  ALU result.
- `rsp_ready`  in  1  consumer accepts the result.
- `op_count`  out  8  completed operations; wraps 255 -> 0.

## Operation

Opcodes:
- 00: a+b
- 01: a|b
- 10: a-b
- 11: a^b

Arithmetic is modulo 2^N. Carry and borrow are discarded.

State machine states: IDLE, EXEC, RESP.

- IDLE:
  - `reqX_ready` is combinational: high only for the granted requester, and only when that requester's valid is high.
  - Grant, only one valid: that requester wins regardless of `prio`.
  - Grant, both valid: the requester selected by `prio` wins.
  - On valid&&ready: latch a, b, op and the grant ID into internal registers; set `prio` to the other requester; go to EXEC.
  - The losing requester's ready stays low. It must hold valid and data stable until accepted.
- EXEC (exactly 1 cycle):
  - The ALU is driven from the latched registers.
  - Capture the result into `rsp_result` and the ID into `rsp_id`; set `rsp_valid`=1; go to RESP.
  - Both readys are low.
- RESP:
  - `rsp_valid`, `rsp_result` and `rsp_id` are held stable until `rsp_ready`.
  - On `rsp_valid`&&`rsp_ready`: clear `rsp_valid`, increment `op_count`, go to IDLE.
  - Both readys are low.
- `prio` resets to 0, so requester 0 has priority first.
- Inputs with valid low are ignored, including X data.

## Timing

- Reset values:
  - state=IDLE, `prio`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `op_count`=0.
  - All internal operand registers = 0.
  - `req0_ready` and `req1_ready` follow the IDLE combinational rule: a requester with valid high during reset deassertion is granted immediately.
- Latency: handshake at edge k gives `rsp_valid` high after edge k+1. The earliest response-handshake edge is k+2; the earliest next accept is edge k+3.
- Peak throughput: one operation per 3 cycles with `rsp_ready` tied high.
- `rsp_ready` stalls: the hold is unbounded. No new request is accepted while `rsp_valid`=1.
- `op_count` updates on the response-handshake edge. At 255 it wraps to 0; there is no saturation.
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded. No response is produced, `op_count` is not incremented, and `prio` returns to 0.
- Requester changes valid/data while not granted: no effect.

## Test plan

- **Reset:** assert `rst` asynchronously mid-cycle -> all outputs at reset values immediately. After release, `req0_valid`=1 with a=4'h3, b=4'h5, op=00 -> `req0_ready`=1 that cycle; two edges later `rsp_valid`=1, `rsp_id`=0, `rsp_result`=4'h8.
- **All opcodes and wrap-around:** a=4'hF, b=4'h2 -> op 00 gives 4'h1, op 10 gives 4'hD, op 01 gives 4'hF, op 11 gives 4'hD. With a=4'h2, b=4'h5, op 10 -> 4'hD (borrow discarded).
- **Contention:** both valid continuously, each issuing different ops -> grants alternate 0,1,0,1. `rsp_id` sequence is 0,1,0,1. Each request's result matches its own operands.
- **Back-pressure:** `rsp_ready`=0 for 5 cycles after `rsp_valid` rises -> `rsp_result` and `rsp_id` stay stable, both readys stay 0, and `op_count` is unchanged until the handshake.
- **Reset during RESP:** assert `rst` while `rsp_valid`=1 -> `rsp_valid` drops to 0 and `op_count` stays unchanged. The next request from requester 1 alone is granted; with both valid, requester 0 wins (`prio` reset).
- **Counter wrap and random soak:** 256 random transactions against a reference model -> `op_count` returns to 0 and all results match.
